period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
- REQ-001 SHALL have parameter WIDTH, default 27, the bit width of the period counter and result.
- REQ-002 SHALL have parameter DEB_CYCLES, default 16, the input stable-time in clocks (used only with PERIOD_METER_DEBOUNCE_EN).
- REQ-003 SHALL have port clock, input, 1, the single system clock; all flops are on its rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port sig_in, input, 1, asynchronous toggling signal under measurement (LED or KEY line).
- REQ-006 SHALL have port level, output, 1, synchronized (and, if enabled, debounced) copy of sig_in.
- REQ-007 SHALL have port period, output, WIDTH, clocks between the last two accepted edges.
- REQ-008 SHALL have port period_valid, output, 1, one-cycle pulse when period updates.
- REQ-009 SHALL have port timeout, output, 1, level high while the counter is saturated with no edge.

Function
- REQ-010 SHALL pass sig_in through a 2-flop synchronizer before any other use.
- REQ-011 SHALL treat both rising and falling transitions of level as edges; one edge is detected per level change.
- REQ-012 SHALL implement states IDLE, RUN, SAT.
- REQ-013 IDLE: counter held at 0; on the first edge, go to RUN and clear the counter; no period_valid.
- REQ-014 RUN: counter increments by 1 each clock; on an edge, load period with the number of clocks since the previous edge, pulse period_valid, and restart the counter in the same cycle.
- REQ-015 RUN: when the counter reaches 2^WIDTH-1 with no edge, go to SAT and set timeout.
- REQ-016 SAT: counter holds at 2^WIDTH-1 and period is unchanged; on an edge, go to RUN with the counter restarted, clear timeout, and do not pulse period_valid.
- REQ-017 An edge in the same cycle as saturation SHALL take precedence: period = 2^WIDTH-1 and valid pulses.
- REQ-018 Latency SHALL be a fixed 3 clocks from sig_in change to period_valid for both polarities, so the measured difference is exact.
- REQ-019 period SHALL hold its value between updates; period_valid is never high for two consecutive cycles.

Reset
- REQ-020 While reset is high, the block SHALL be in IDLE with period=0, period_valid=0, timeout=0, level=0, and all synchronizer and debounce flops at 0.
- REQ-021 Reset asserted mid-measurement SHALL discard the partial count; the first edge after release only arms measurement.

Configuration
- REQ-022 With PERIOD_METER_DEBOUNCE_EN defined, level SHALL change only after the synchronized input differs from level for DEB_CYCLES consecutive clocks; shorter glitches produce no edge. Latency grows by DEB_CYCLES.
- REQ-023 Without PERIOD_METER_DEBOUNCE_EN, level SHALL equal the 2nd synchronizer flop; DEB_CYCLES is ignored and no debounce logic is built.

Structure
- REQ-024 SHALL place the state enum (IDLE/RUN/SAT) and the default WIDTH/DEB_CYCLES constants in shared package period_meter_pkg.
- REQ-025 SHALL implement synchronizer, optional debounce and edge detect in sub-module edge_sync (outputs level, edge); the FSM and counter stay in period_meter.

Verification
- REQ-026 Square wave, WIDTH=27, toggling every 100 clocks -> first edge gives no valid; each later edge gives period=100 with a single-cycle period_valid.
- REQ-027 WIDTH=8, sig_in static for 300 clocks after arming -> timeout rises exactly 255 clocks after the arming edge; the next edge clears timeout with no valid, and the edge after that reports the true spacing.
- REQ-028 Reset pulsed 40 clocks into a 100-clock half-period -> outputs are 0 during reset, the first post-reset edge gives no valid, and the next edge gives period=100.
- REQ-029 With PERIOD_METER_DEBOUNCE_EN and DEB_CYCLES=16, a 5-clock glitch -> no level change and no valid; a 20-clock-stable change -> level toggles 2+16 clocks after the input change.
- REQ-030 Alternating half-periods of 7 and 13 clocks -> period alternates 7/13, which confirms equal rise and fall latency.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the period meter.
// State encoding and default parameter values only; no logic.
// No flow control; constants only.
package period_meter_pkg;

  localparam int WIDTH_DEF      = 27;
  localparam int DEB_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes sig_in, optionally debounces it (PERIOD_METER_DEBOUNCE_EN), flags each level change.
// Latency: level 2 clocks after sig_in (plus DEB_CYCLES when debounced); edge_det combinational from level.
// No backpressure: edge_det is a single-cycle strobe per level change.
module edge_sync import period_meter_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic level,
  output logic edge_det
);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("edge_sync: DEB_CYCLES must be at least 1");
  end

  logic sync1;
  logic sync2;
  logic level_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
    end
  end

`ifdef PERIOD_METER_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] stable_cnt;
  logic          deb_level;

  // level follows sync2 only after DEB_CYCLES consecutive disagreeing clocks
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      deb_level  <= 1'b0;
    end else if (sync2 == deb_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
      stable_cnt <= '0;
      deb_level  <= sync2;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign level = deb_level;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  // both polarities go through the same flops, so rise and fall latency match
  assign edge_det = level ^ level_d;

endmodule

// File: rtl/period_meter.sv
// Measures clocks between successive edges (either polarity) of sig_in; optional debounce via PERIOD_METER_DEBOUNCE_EN.
// Latency: period_valid 3 clocks after the sig_in change (3 + DEB_CYCLES when debounced).
// No backpressure: period_valid is a single-cycle pulse, period holds until the next update.
module period_meter import period_meter_pkg::*; #(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic             level,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             edge_det;
  logic             report;
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;

  edge_sync #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_edge_sync (
    .clock    (clock),
    .reset    (reset),
    .sig_in   (sig_in),
    .level    (level),
    .edge_det (edge_det)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (edge_det) state_nxt = RUN;
      RUN:     if (!edge_det && cnt == CNT_MAX) state_nxt = SAT;
      SAT:     if (edge_det) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    report  = (state == RUN) && edge_det;
    timeout = (state == SAT);
  end

  // cnt holds the clocks elapsed since the last edge, so the edge cycle itself reloads 1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= report;
      if (report) begin
        period <= cnt;
      end
      if (edge_det) begin
        cnt <= WIDTH'(1);
      end else if (state == RUN && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: two widths driven by one input, random and directed edge spacing.
module tb_period_meter;

  localparam int W0   = 27;
  localparam int W1   = 8;
`ifdef PERIOD_METER_DEBOUNCE_EN
  localparam int DEB  = 16;
`else
  localparam int DEB  = 0;
`endif
  localparam int THR  = (DEB > 0) ? DEB : 1;
  localparam int NCYC = 32768;

  typedef struct {
    longint o;
    longint p;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sig_in = 1'b0;
  logic          level0, level1;
  logic          pv0, pv1;
  logic          to0, to1;
  logic [W0-1:0] per0;
  logic [W1-1:0] per1;

  period_meter #(.WIDTH(W0), .DEB_CYCLES(16)) dut0 (
    .clock(clock), .reset(reset), .sig_in(sig_in),
    .level(level0), .period(per0), .period_valid(pv0), .timeout(to0)
  );

  period_meter #(.WIDTH(W1), .DEB_CYCLES(16)) dut1 (
    .clock(clock), .reset(reset), .sig_in(sig_in),
    .level(level1), .period(per1), .period_valid(pv1), .timeout(to1)
  );

  always #5 clock = ~clock;

  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  longint maxv[2];
  exp_t   q[2][$];
  bit     chg_at[NCYC];
  bit     arm_at[NCYC];

  // reference model state (stimulus side)
  logic   eff = 1'b0;
  int     run = 0;
  bit     armed[2];
  longint last_o[2];
  logic   cur = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, k, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model decides when an accepted edge lands and what it reports.
  task automatic step(input logic s, input logic r);
    longint o;
    exp_t   e;
    @(posedge clock);
    #1;
    if (cyc >= NCYC - 16) begin
      $display("FAIL budget: cycle %0d exceeds limit %0d", cyc, NCYC - 16);
      $fatal(1, "cycle budget exhausted");
    end
    sig_in = s;
    reset  = r;
    if (r) begin
      eff = 1'b0;
      run = 0;
      for (int k = 0; k < 2; k++) begin
        armed[k] = 1'b0;
        q[k].delete();
      end
      for (int i = cyc + 1; i <= cyc + 8; i++) begin
        chg_at[i] = 1'b0;
        arm_at[i] = 1'b0;
      end
    end else begin
      if (s != eff) run++;
      else run = 0;
      if (run == THR) begin
        eff = s;
        run = 0;
        o = longint'(cyc) - THR + 1 + 3 + DEB;
        chg_at[o-1] = 1'b1;
        arm_at[o]   = 1'b1;
        for (int k = 0; k < 2; k++) begin
          if (armed[k] && (o - last_o[k]) <= maxv[k]) begin
            e.o = o;
            e.p = o - last_o[k];
            q[k].push_back(e);
          end
          armed[k]  = 1'b1;
          last_o[k] = o;
        end
      end
    end
  endtask

  task automatic th(input int n);
    cur = ~cur;
    repeat (n) step(cur, 1'b0);
  endtask

  // monitor: pops expected pulses and tracks level/timeout/period expectations
  bit     m_armed[2];
  longint m_last[2];
  longint exp_p[2];
  logic   exp_lvl = 1'b0;

  always @(negedge clock) begin
    logic [63:0] ap[2];
    logic        av[2];
    logic        ato[2];
    logic        alv[2];
    logic        ev;
    logic        eto;
    av[0] = pv0;  av[1] = pv1;
    ap[0] = 64'(per0); ap[1] = 64'(per1);
    ato[0] = to0; ato[1] = to1;
    alv[0] = level0; alv[1] = level1;
    if (reset) begin
      exp_lvl = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_armed[k] = 1'b0;
        exp_p[k]   = 0;
      end
    end else begin
      if (chg_at[cyc]) exp_lvl = ~exp_lvl;
      if (arm_at[cyc]) begin
        for (int k = 0; k < 2; k++) begin
          m_armed[k] = 1'b1;
          m_last[k]  = cyc;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      ev = !reset && q[k].size() > 0 && q[k][0].o == cyc;
      if (ev) begin
        exp_p[k] = q[k][0].p;
        void'(q[k].pop_front());
      end
      eto = m_armed[k] && (longint'(cyc) >= m_last[k] + maxv[k]);
      chk("valid", k, 64'(av[k]), 64'(ev));
      chk("period", k, ap[k], exp_p[k]);
      chk("timeout", k, 64'(ato[k]), 64'(eto));
      chk("level", k, 64'(alv[k]), 64'(exp_lvl));
    end
  end

  initial begin
    maxv[0] = (longint'(1) << W0) - 1;
    maxv[1] = (longint'(1) << W1) - 1;
    for (int k = 0; k < 2; k++) begin
      armed[k]  = 1'b0;
      last_o[k] = 0;
      m_armed[k] = 1'b0;
      m_last[k]  = 0;
      exp_p[k]   = 0;
    end
    repeat (4) step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);

    // square wave, 100-clock half period
    repeat (7) th(100);

    // alternating 7/13 half periods
    repeat (6) begin
      th(7);
      th(13);
    end

    // long static stretch: saturates the 8-bit instance only
    th(300);
    th(120);
    th(60);

    // reset 40 clocks into a 100-clock half period
    th(100);
    cur = ~cur;
    repeat (40) step(cur, 1'b0);
    repeat (3) step(cur, 1'b1);
    repeat (57) step(cur, 1'b0);
    th(100);
    th(100);
    th(100);

`ifdef PERIOD_METER_DEBOUNCE_EN
    th(40);
    th(5);
    th(40);
    th(20);
    th(40);
`endif

    repeat (40) th($urandom_range((DEB > 0) ? 1 : 2, 400));
    repeat (40) step(cur, 1'b0);

    for (int k = 0; k < 2; k++) begin
      chk("drain", k, 64'(q[k].size()), 64'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
